npc_ctrl: RTL
=============

# npc_ctrl

Multi-cycle sequencer for the NPC core's execute datapath. It accepts instructions from the fetch unit over a valid/ready handshake, decodes them, and drives the ALU controls (opcode, funct3, sign-extended immediate, rs1 address). It captures the ALU result and issues a single register-file write per instruction. It also owns the PC, the retired-instruction counter, and the halt/illegal status flags.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_valid  in  1  fetch unit presents a valid instruction.
- inst  in  32  instruction word; sampled on handshake.
- inst_ready  out  1  controller accepts an instruction this cycle.
- pc  out  32  address of the current instruction.
- alu_oc  out  7  opcode to ALU (IR[6:0]).
- alu_funct3  out  3  funct3 to ALU (IR[14:12]).
- alu_imm  out  32  I-type immediate, sign-extended from IR[31:20].
- rs1_addr  out  5  register-file read address (IR[19:15]).
- alu_result  in  32  ALU output.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  write address.
- rf_wdata  out  32  write data.
- halt  out  1  sticky; ebreak or illegal instruction reached.
- illegal  out  1  sticky; unsupported instruction trapped.
- retire_cnt  out  32  count of retired instructions.

## Operation
- States: FETCH, DECODE, EXEC, WB, HALT.
- Reset state is FETCH.
- inst_ready = (state == FETCH), combinational.
- FETCH: on inst_valid && inst_ready, latch inst into IR and go to DECODE. Otherwise stay in FETCH; stalls are unbounded.
- DECODE classifies IR:
  - addi (opcode 0010011, funct3 000): go to EXEC.
  - ebreak (32'h0010_0073): go to HALT; set halt.
  - anything else: handled per Configuration.
- EXEC: result_q <= alu_result; go to WB.
- WB:
  - rf_we = 1 for exactly this cycle, only if rd (IR[11:7]) != 0.
  - rf_waddr = rd; rf_wdata = result_q.
  - pc <= pc + 4, wrapping modulo 2^32.
  - retire_cnt <= retire_cnt + 1, wrapping modulo 2^32.
  - Go to FETCH.
- HALT: absorbing state. inst_ready = 0 and rf_we = 0. pc and retire_cnt are frozen. Only reset exits HALT.
- alu_oc, alu_funct3, alu_imm and rs1_addr decode IR combinationally. They are stable from DECODE through WB and change only at the next handshake.
- ebreak does not increment retire_cnt and does not advance pc.
- rf_we is never asserted outside WB.

## Timing
- Reset (async assert):
  - pc = RESET_PC; IR, result_q, retire_cnt = 0.
  - halt = 0, illegal = 0, rf_we = 0.
  - rf_waddr = 0, rf_wdata = 0.
  - state = FETCH, so inst_ready = 1 in the first cycle after deassertion.
- Reset deassertion is synchronized by the integrating top level; this block treats rst_n as clean.
- Minimum per-instruction latency is 4 cycles: handshake, DECODE, EXEC, WB. The next handshake can occur in the cycle after WB.
- With inst_valid held high, an addi retires every 4 cycles.
- Asserting rst_n low in any state, including mid-EXEC or mid-WB, aborts the instruction:
  - No register-file write completes after the reset edge.
  - pc and retire_cnt return to their reset values immediately.
- The fetch unit must hold inst stable while inst_valid is high and inst_ready is low. The controller samples inst only in the handshake cycle.

## Configuration
- Macro: NPC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unsupported instruction in DECODE sets illegal = 1 and halt = 1 and goes to HALT. pc stays at the faulting address, no write occurs, and retire_cnt is unchanged.
- Undefined: an unsupported instruction is a NOP. DECODE goes to WB with the write suppressed; pc += 4 and retire_cnt += 1. illegal is tied to 0.

## Test plan
- Reset release with inst_valid = 0 -> pc = 0x8000_0000, inst_ready = 1, and it stays in FETCH for 10 cycles with no rf_we.
- inst = 0x0050_0093 (addi x1, x0, 5), model alu_result = 5:
  - alu_imm = 5 and rs1_addr = 0 during DECODE/EXEC.
  - Exactly 3 cycles after the handshake: rf_we = 1 for one cycle, rf_waddr = 1, rf_wdata = 5.
  - pc = 0x8000_0004, retire_cnt = 1.
- inst = 0xFFF0_0013 (addi x0, x0, -1) -> alu_imm = 0xFFFF_FFFF, rf_we stays 0, pc advances by 4, retire_cnt increments.
- inst = 0x0010_0073 (ebreak) -> halt = 1 two cycles after the handshake. inst_ready then stays 0 and pc/retire_cnt are frozen, with inst_valid held high for 20 cycles.
- inst = 0x0000_0033 (add):
  - With NPC_CTRL_ILLEGAL_TRAP_EN: illegal = halt = 1, pc unchanged.
  - Without it: NOP, pc += 4, retire_cnt += 1, illegal = 0.
- rst_n pulsed low during EXEC of addi x2, x0, 7 -> no rf_we is ever asserted, pc = 0x8000_0000 and retire_cnt = 0 after reset. The same instruction re-fetched afterwards writes x2 = 7.

Source files
------------

// File: rtl/npc_ctrl.sv
// ---------------------------------------------------------------------------
// npc_ctrl -- multi-cycle sequencer for the NPC execute datapath.
//
// Accepts one instruction at a time from fetch (valid/ready), walks it through
// FETCH -> DECODE -> EXEC -> WB, drives the ALU decode fields from the latched
// instruction register, captures the ALU result and issues at most one
// register-file write per instruction. Owns the PC, the retired-instruction
// counter and the sticky halt/illegal status flags.
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   inst_valid, inst           instruction offer from fetch
//   inst_ready                 high while waiting in FETCH
//   pc                         address of the current instruction
//   alu_oc, alu_funct3,        ALU controls decoded from the latched IR
//   alu_imm, rs1_addr
//   alu_result                 ALU output, captured in EXEC
//   rf_we, rf_waddr, rf_wdata  register-file write port (WB only)
//   halt, illegal              sticky status flags
//   retire_cnt                 count of retired instructions
//
// Configuration macro: NPC_CTRL_ILLEGAL_TRAP_EN
//   defined   -> unsupported instructions trap (illegal = halt = 1, go HALT)
//   undefined -> unsupported instructions retire as NOPs, illegal tied to 0
// ---------------------------------------------------------------------------
module npc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  output logic [31:0] pc,
  output logic [6:0]  alu_oc,
  output logic [2:0]  alu_funct3,
  output logic [31:0] alu_imm,
  output logic [4:0]  rs1_addr,
  input  logic [31:0] alu_result,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        halt,
  output logic        illegal,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [6:0]  OP_IMM    = 7'b001_0011;
  localparam logic [2:0]  F3_ADDI   = 3'b000;
  localparam logic [31:0] EBREAK_IW = 32'h0010_0073;

  // Instruction classification helpers, evaluated on the latched IR.
  function automatic logic is_addi(input logic [31:0] iw);
    is_addi = (iw[6:0] == OP_IMM) && (iw[14:12] == F3_ADDI);
  endfunction

  function automatic logic is_ebreak(input logic [31:0] iw);
    is_ebreak = (iw == EBREAK_IW);
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [31:0] ir_r;
  logic [31:0] result_r;
  logic [31:0] pc_r;
  logic [31:0] retire_r;
  logic        rf_we_r;
  logic [4:0]  rf_waddr_r;
  logic        halt_r;
  logic        handshake_s;
  logic        to_halt_s;

  assign handshake_s = (state_r == ST_FETCH) && inst_valid;
  // Taken only from DECODE; the trap build also routes unsupported opcodes here.
  assign to_halt_s   = (state_r == ST_DECODE) && (state_s == ST_HALT);

  // Next-state selection for the instruction sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (inst_valid) begin
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_addi(ir_r)) begin
          state_s = ST_EXEC;
        end else if (is_ebreak(ir_r)) begin
          state_s = ST_HALT;
        end else begin
`ifdef NPC_CTRL_ILLEGAL_TRAP_EN
          state_s = ST_HALT;
`else
          // Unsupported instruction retires as a NOP without a write.
          state_s = ST_WB;
`endif
        end
      end
      ST_EXEC:  state_s = ST_WB;
      ST_WB:    state_s = ST_FETCH;
      ST_HALT:  state_s = ST_HALT;
      default:  state_s = ST_FETCH;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Instruction register: loaded only on the fetch handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_r <= 32'h0000_0000;
    end else if (handshake_s) begin
      ir_r <= inst;
    end
  end

  // ALU result capture in EXEC; this flop is the write-data source in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= 32'h0000_0000;
    end else if (state_r == ST_EXEC) begin
      result_r <= alu_result;
    end
  end

  // Register-file write strobe/address, set on the EXEC->WB edge so they are
  // high for exactly the WB cycle. The NOP path enters WB from DECODE and
  // therefore never raises the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= 5'd0;
    end else if (state_r == ST_EXEC) begin
      rf_we_r    <= (ir_r[11:7] != 5'd0);
      rf_waddr_r <= ir_r[11:7];
    end else begin
      rf_we_r    <= 1'b0;
    end
  end

  // PC and retire counter advance once per retired instruction (in WB).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r     <= RESET_PC;
      retire_r <= 32'h0000_0000;
    end else if (state_r == ST_WB) begin
      pc_r     <= pc_r + 32'd4;
      retire_r <= retire_r + 32'd1;
    end
  end

  // Sticky halt flag, set on entry to HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_r <= 1'b0;
    end else if (to_halt_s) begin
      halt_r <= 1'b1;
    end
  end

`ifdef NPC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky illegal flag: HALT entered from DECODE by something other than ebreak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else if (to_halt_s && !is_ebreak(ir_r)) begin
      illegal_r <= 1'b1;
    end
  end

  assign illegal = illegal_r;
`else
  assign illegal = 1'b0;
`endif

  assign inst_ready = (state_r == ST_FETCH);
  assign pc         = pc_r;
  assign retire_cnt = retire_r;
  assign halt       = halt_r;
  assign rf_we      = rf_we_r;
  assign rf_waddr   = rf_waddr_r;
  assign rf_wdata   = result_r;

  // Decode fields follow the IR, so they only change at a handshake.
  assign alu_oc     = ir_r[6:0];
  assign alu_funct3 = ir_r[14:12];
  assign alu_imm    = {{20{ir_r[31]}}, ir_r[31:20]};
  assign rs1_addr   = ir_r[19:15];

endmodule
